// File: rtl/vector_load_unit.sv
// Vector load sequencer: fetches NUM_LANES consecutive words from data memory one at a time,
// packs them into a vector and writes it to the vector register file in a single cycle.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for a load request; misaligned requests raise err
// S_ISSUE | memory read request presented for lane idx
// S_WAIT  | waiting for the read response of lane idx
// S_WRITE | one-cycle register-file write of the packed vector
module vector_load_unit #(
  parameter int REG_WIDTH  = 256,
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_base,
  input  logic [4:0]            req_rd,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_rsp_valid,
  input  logic [WORD_WIDTH-1:0] mem_rsp_data,
  output logic                  rf_we,
  output logic [4:0]            rf_addr,
  output logic [REG_WIDTH-1:0]  rf_wd,
  output logic                  busy,
  output logic                  err
);

  localparam int NUM_LANES = REG_WIDTH / WORD_WIDTH;
  localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);
  localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(WORD_WIDTH / 8);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic             aligned;
  logic             accept;
  logic             lane_done;
  logic             busy_nxt;
  logic             mem_req_valid_nxt;
  logic             rf_we_nxt;
  logic             err_nxt;

  assign aligned   = (req_base[1:0] == 2'b00);
  assign accept    = (state == S_IDLE) && req_valid && aligned;
  assign lane_done = (state == S_WAIT) && mem_rsp_valid;
  assign req_ready = (state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_valid && aligned) state_nxt = S_ISSUE;
      S_ISSUE: if (mem_req_ready) state_nxt = S_WAIT;
      S_WAIT:  if (mem_rsp_valid) state_nxt = (idx == LAST_IDX) ? S_WRITE : S_ISSUE;
      S_WRITE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the next state.
  always_comb begin
    busy_nxt          = (state_nxt != S_IDLE);
    mem_req_valid_nxt = (state_nxt == S_ISSUE);
    rf_we_nxt         = (state_nxt == S_WRITE);
    err_nxt           = (state == S_IDLE) && req_valid && !aligned;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy          <= 1'b0;
      mem_req_valid <= 1'b0;
      rf_we         <= 1'b0;
      err           <= 1'b0;
      mem_addr      <= '0;
      rf_addr       <= '0;
      rf_wd         <= '0;
      idx           <= '0;
    end else begin
      busy          <= busy_nxt;
      mem_req_valid <= mem_req_valid_nxt;
      rf_we         <= rf_we_nxt;
      err           <= err_nxt;
      if (accept) begin
        mem_addr <= req_base;
        rf_addr  <= req_rd;
        idx      <= '0;
      end else if (lane_done) begin
        // rf_wd doubles as the assembly buffer; all lanes are rewritten before rf_we.
        for (int i = 0; i < NUM_LANES; i++) begin
          if (idx == IDX_W'(i)) rf_wd[i*WORD_WIDTH +: WORD_WIDTH] <= mem_rsp_data;
        end
        if (idx != LAST_IDX) begin
          idx      <= idx + IDX_W'(1);
          mem_addr <= mem_addr + WORD_BYTES;
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_load_unit.sv
// Scoreboard bench for vector_load_unit: a memory model answers reads with random stalls/delays,
// expected vectors are queued at request time and checked by a monitor on every rf_we.
module tb_vector_load_unit;

  localparam int RW = 256;
  localparam int WW = 32;
  localparam int AW = 32;
  localparam int NL = RW / WW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_base;
  logic [4:0]    req_rd;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_rsp_valid;
  logic [WW-1:0] mem_rsp_data;
  logic          rf_we;
  logic [4:0]    rf_addr;
  logic [RW-1:0] rf_wd;
  logic          busy;
  logic          err;

  vector_load_unit #(.REG_WIDTH(RW), .WORD_WIDTH(WW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_base(req_base), .req_rd(req_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wd(rf_wd), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]    rd;
    logic [RW-1:0] data;
    int            lat;
    int            c0;
  } sb_t;

  sb_t           exp_q[$];
  logic [AW-1:0] addr_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int rsp_count = 0;

  int            cfg_stall = 0;
  int            cfg_maxd = 0;
  bit            cfg_spur = 1'b0;
  bit            seq_mode = 1'b0;
  logic [AW-1:0] seq_base = '0;
  logic [WW-1:0] salt = '0;

  function automatic logic [WW-1:0] mem_word(input logic [AW-1:0] a);
    if (seq_mode) return ((a - seq_base) >> 2) + 32'd1;
    return (a * 32'h9E3779B1) ^ salt;
  endfunction

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic checki(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Memory model: stalls acceptance, delays the response, optionally injects beats during ISSUE.
  initial begin
    int            phase;
    int            delay;
    int            stall_left;
    bit            held;
    logic [AW-1:0] haddr;
    phase = 0; delay = 0; stall_left = 0; held = 1'b0; haddr = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    forever begin
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      if (!rst_n) begin
        phase = 0;
        held  = 1'b0;
      end else if (phase == 1) begin
        if (delay > 0) delay--;
        else begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = mem_word(haddr);
          rsp_count++;
          phase = 0;
        end
      end else if (mem_req_valid) begin
        if (!held) begin
          held  = 1'b1;
          haddr = mem_addr;
          if (addr_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_mem_req: got request to %h, required no request", mem_addr);
          end else check("mem_addr", RW'(mem_addr), RW'(addr_q.pop_front()));
          stall_left = (cfg_stall < 0) ? int'($urandom_range(0, 3)) : cfg_stall;
        end else check("mem_addr_stable", RW'(mem_addr), RW'(haddr));
        if (cfg_spur && $urandom_range(0, 1) == 1) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = 32'hDEADBEEF;
        end
        if (stall_left > 0) stall_left--;
        else begin
          mem_req_ready = 1'b1;
          held  = 1'b0;
          phase = 1;
          delay = int'($urandom_range(0, cfg_maxd));
        end
      end else if (held) begin
        checki("mem_req_valid_stable", int'(mem_req_valid), 1);
        held = 1'b0;
      end
    end
  end

  // Monitor: every rf_we must match the oldest queued load.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rf_we) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_rf_we: got rf_we=1 rf_addr=%0d, required rf_we=0", rf_addr);
        end else begin
          e = exp_q.pop_front();
          check("rf_addr", RW'(rf_addr), RW'(e.rd));
          check("rf_wd", rf_wd, e.data);
          if (e.lat >= 0) checki("rf_we_cycle", cyc - e.c0, e.lat);
          done_cnt++;
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    checki({tag, "_req_ready"}, int'(req_ready), 1);
    checki({tag, "_busy"}, int'(busy), 0);
    checki({tag, "_mem_req_valid"}, int'(mem_req_valid), 0);
    checki({tag, "_rf_we"}, int'(rf_we), 0);
    checki({tag, "_err"}, int'(err), 0);
    check({tag, "_mem_addr"}, RW'(mem_addr), '0);
    check({tag, "_rf_addr"}, RW'(rf_addr), '0);
    check({tag, "_rf_wd"}, rf_wd, '0);
  endtask

  task automatic handshake(input logic [AW-1:0] base, input logic [4:0] rd);
    int t;
    @(negedge clk);
    req_valid = 1'b1; req_base = base; req_rd = rd;
    t = 0;
    while (!req_ready && t < 200) begin @(negedge clk); t++; end
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL req_ready_timeout: got req_ready=0, required 1");
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_load(input logic [AW-1:0] base, input logic [4:0] rd, input int stall,
                         input int maxd, input bit spur, input int lat, input bit chk_busy);
    sb_t           e;
    logic [AW-1:0] a;
    int            target;
    int            t;
    int            bad_busy;
    cfg_stall = stall; cfg_maxd = maxd; cfg_spur = spur;
    e.rd = rd; e.lat = lat; e.data = '0;
    for (int i = 0; i < NL; i++) begin
      a = base + AW'(4 * i);
      addr_q.push_back(a);
      e.data[i*WW +: WW] = mem_word(a);
    end
    handshake(base, rd);
    e.c0 = cyc - 1;
    target = done_cnt + 1;
    exp_q.push_back(e);
    if (chk_busy) begin
      bad_busy = 0;
      for (int c = 1; c <= 18; c++) begin
        if (c > 1) @(negedge clk);
        if (busy !== (c <= 17)) bad_busy++;
      end
      checki("busy_window_errors", bad_busy, 0);
      checki("req_ready_cycle18", int'(req_ready), 1);
    end
    t = 0;
    while (done_cnt < target && t < 3000) begin @(negedge clk); t++; end
    if (done_cnt < target) begin
      n_cmp++; n_bad++;
      $display("FAIL load_timeout: got no rf_we for rd=%0d, required one", rd);
      exp_q.delete();
      addr_q.delete();
    end
  endtask

  task automatic do_misaligned(input logic [AW-1:0] base);
    int errs;
    int notready;
    cfg_stall = 0; cfg_maxd = 0; cfg_spur = 1'b0;
    handshake(base, 5'd7);
    checki("err_cycle1", int'(err), 1);
    checki("misaligned_req_ready", int'(req_ready), 1);
    errs = 0; notready = 0;
    repeat (5) begin
      @(negedge clk);
      if (err) errs++;
      if (!req_ready) notready++;
    end
    checki("err_extra_pulses", errs, 0);
    checki("misaligned_not_ready_cycles", notready, 0);
  endtask

  initial begin
    int            t;
    logic [AW-1:0] b;
    logic [4:0]    r;
    req_valid = 1'b0; req_base = '0; req_rd = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;

    seq_mode = 1'b1; seq_base = 32'h100;
    do_load(32'h100, 5'd5, 0, 0, 1'b0, 17, 1'b1);

    seq_mode = 1'b0; salt = $urandom;
    do_load(32'h2000_0040, 5'd9, 3, 0, 1'b0, 41, 1'b0);

    for (int i = 0; i < 6; i++) begin
      b = $urandom;
      b[1:0] = 2'b00;
      r = (i == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      do_load(b, r, -1, 5, 1'b1, -1, 1'b0);
    end

    do_misaligned(32'h102);
    do_load(32'h3000, 5'd12, 0, 0, 1'b0, 17, 1'b0);

    // Abort a load after three returned words.
    cfg_stall = 0; cfg_maxd = 0; cfg_spur = 1'b0;
    for (int i = 0; i < NL; i++) addr_q.push_back(32'h4000 + AW'(4 * i));
    rsp_count = 0;
    handshake(32'h4000, 5'd11);
    t = 0;
    while (rsp_count < 3 && t < 200) begin @(negedge clk); t++; end
    checki("abort_words_returned", rsp_count, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_vals("mid_load_reset");
    @(negedge clk);
    addr_q.delete();
    check_reset_vals("held_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    salt = $urandom;
    do_load(32'h5000, 5'd6, 0, 0, 1'b0, 17, 1'b0);

    do_load(32'hFFFF_FFF8, 5'd21, 0, 2, 1'b0, -1, 1'b0);

    repeat (10) @(negedge clk);
    checki("exp_queue_drained", exp_q.size(), 0);
    checki("addr_queue_drained", addr_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no completion, required $finish before 500000 ns");
    $fatal(1, "timeout");
  end

endmodule
